// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by fetch_unit and fetch_out_buffer.
package fetch_pkg;

  localparam int unsigned PC_WIDTH = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_buffer.sv
// Single-entry instruction/PC holding register towards decode.
// Load fills it, a valid/ready handshake empties it, flush drops it.
module fetch_out_buffer
  import fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [31:0]         load_instr,
  input  logic [PC_WIDTH-1:0] load_pc,
  input  logic                flush,
  input  logic                ready,
  output logic                valid,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] pc
);

  // Entry state: flush wins, then load, then consumption by decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, one outstanding imem request.
// Optional misaligned-PC trap under FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned         PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rdata,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [31:0]         instruction,
  output logic [PC_WIDTH-1:0] instr_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                fetch_misaligned,
  output logic [PC_WIDTH-1:0] fetch_bad_pc,
`endif
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  fetch_state_t        state, state_n;
  logic [PC_WIDTH-1:0] pc, pc_n;
  logic [PC_WIDTH-1:0] inflight_pc, inflight_n;
  logic [PC_WIDTH-1:0] redir_tgt;
  logic                accept;
  logic                misalign;
  logic                buf_load;
  logic                buf_flush;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_set;
  logic trap_clr;

  assign redir_tgt = redirect_pc;
  assign misalign  = |pc[1:0];
`else
  logic redir_lsb_unused;

  assign redir_lsb_unused = ^redirect_pc[1:0];
  assign redir_tgt = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign misalign  = 1'b0;
`endif

  assign imem_req_valid = (state == REQ) && !misalign;
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Next state, PC and buffer control; redirect beats sequential flow
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    inflight_n = inflight_pc;
    buf_load   = 1'b0;
    buf_flush  = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_set   = 1'b0;
    trap_clr   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        state_n = REQ;
        if (redirect_valid) pc_n = redir_tgt;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_n    = redir_tgt;
          state_n = accept ? DRAIN : REQ;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        else if (misalign) begin
          state_n  = HALT;
          trap_set = 1'b1;
        end
`endif
        else if (accept) begin
          inflight_n = pc;
          pc_n       = pc + STEP;
          state_n    = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_n    = redir_tgt;
          state_n = imem_rsp_valid ? REQ : DRAIN;
        end else if (imem_rsp_valid) begin
          buf_load = 1'b1;
          state_n  = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n      = redir_tgt;
          buf_flush = 1'b1;
          state_n   = REQ;
        end else if (instr_ready) begin
          state_n = REQ;
        end
      end
      DRAIN: begin
        if (redirect_valid) pc_n = redir_tgt;
        if (imem_rsp_valid) state_n = REQ;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      HALT: begin
        if (redirect_valid) begin
          pc_n     = redir_tgt;
          trap_clr = 1'b1;
          state_n  = REQ;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // FSM state, fetch PC and the PC of the request in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight_pc <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      inflight_pc <= inflight_n;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Misaligned-fetch flag and offending PC, cleared by redirect out of HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_misaligned <= 1'b0;
      fetch_bad_pc     <= '0;
    end else if (trap_set) begin
      fetch_misaligned <= 1'b1;
      fetch_bad_pc     <= pc;
    end else if (trap_clr) begin
      fetch_misaligned <= 1'b0;
    end
  end
`endif

  fetch_out_buffer u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .load_instr (imem_rdata),
    .load_pc    (inflight_pc),
    .flush      (buf_flush),
    .ready      (instr_ready),
    .valid      (instr_valid),
    .instr      (instruction),
    .pc         (instr_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-programmable imem.
// Memory word at address a is a ^ 32'hDEAD_0000.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
  logic [31:0] fetch_bad_pc;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 1;
  int cnt   = 0;
  int n_req = 0;
  int req_mark;
  logic [31:0] rsp_addr = '0;

  fetch_unit #(.RESET_PC(32'h0000_1000), .PC_STEP(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_misaligned (fetch_misaligned),
    .fetch_bad_pc     (fetch_bad_pc),
`endif
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (acc) begin
      cnt      = lat;
      rsp_addr = a;
      n_req++;
    end
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rdata     = rsp_addr ^ 32'hDEAD_0000;
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rdata     = '0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(posedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_addr", imem_addr, 32'h1000);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instruction, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_misaligned", fetch_misaligned, 0);
    check("rst_bad_pc", fetch_bad_pc, 0);
`endif
    rst = 1'b0;

    // sequential fetch, 1-cycle memory, decode always ready
    tick();
    check("seq_req0", imem_req_valid, 1);
    check("seq_addr0", imem_addr, 32'h1000);
    tick();
    check("seq_wait_req", imem_req_valid, 0);
    check("seq_wait_iv", instr_valid, 0);
    tick();
    check("seq_iv0", instr_valid, 1);
    check("seq_instr0", instruction, 32'hDEAD_1000);
    check("seq_pc0", instr_pc, 32'h1000);
    tick();
    check("seq_iv_drop", instr_valid, 0);
    check("seq_addr1", imem_addr, 32'h1004);
    for (int k = 1; k < 3; k++) begin
      tick();
      tick();
      check("seq_iv", instr_valid, 1);
      check("seq_pc", instr_pc, 32'h1000 + 32'(4 * k));
      check("seq_instr", instruction, 32'hDEAD_1000 + 32'(4 * k));
      tick();
      check("seq_next_addr", imem_addr, 32'h1000 + 32'(4 * (k + 1)));
    end

    // decode stall in HOLD
    instr_ready = 1'b0;
    tick();
    tick();
    req_mark = n_req;
    for (int i = 0; i < 5; i++) begin
      check("hold_iv", instr_valid, 1);
      check("hold_pc", instr_pc, 32'h100C);
      check("hold_instr", instruction, 32'hDEAD_100C);
      check("hold_req", imem_req_valid, 0);
      tick();
    end
    check("hold_no_req", n_req, req_mark);
    instr_ready = 1'b1;
    tick();
    check("hold_rel_iv", instr_valid, 0);
    check("hold_rel_addr", imem_addr, 32'h1010);

    // redirect during WAIT, response arrives later and is dropped
    lat = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2000;
    tick();
    redirect_valid = 1'b0;
    check("drain_iv0", instr_valid, 0);
    check("drain_req0", imem_req_valid, 0);
    tick();
    check("drain_iv1", instr_valid, 0);
    check("drain_req1", imem_req_valid, 0);
    tick();
    check("drain_iv2", instr_valid, 0);
    check("drain_req2", imem_req_valid, 1);
    check("drain_addr", imem_addr, 32'h2000);
    lat = 1;
    tick();
    tick();
    check("redir_pc", instr_pc, 32'h2000);
    check("redir_instr", instruction, 32'hDEAD_2000);
    tick();
    check("redir_next", imem_addr, 32'h2004);

    // redirect coincident with response in WAIT
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    tick();
    redirect_valid = 1'b0;
    check("coinc_iv", instr_valid, 0);
    check("coinc_req", imem_req_valid, 1);
    check("coinc_addr", imem_addr, 32'h3000);
    tick();
    tick();
    check("coinc_pc", instr_pc, 32'h3000);
    check("coinc_instr", instruction, 32'hDEAD_3000);
    tick();
    check("coinc_next", imem_addr, 32'h3004);

    // redirect in the same cycle a request is accepted
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4000;
    tick();
    redirect_valid = 1'b0;
    check("acc_redir_req", imem_req_valid, 0);
    check("acc_redir_addr", imem_addr, 32'h4000);
    tick();
    check("acc_redir_iv", instr_valid, 0);
    check("acc_redir_reissue", imem_req_valid, 1);

    // reset mid-WAIT, late response must be ignored
    lat = 3;
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_req", imem_req_valid, 0);
    check("mid_rst_addr", imem_addr, 32'h1000);
    check("mid_rst_iv", instr_valid, 0);
    check("mid_rst_instr", instruction, 32'h0000_0013);
    check("mid_rst_pc", instr_pc, 0);
    tick();
    lat = 1;
    rst = 1'b0;
    tick();
    check("post_rst_req", imem_req_valid, 1);
    check("post_rst_addr", imem_addr, 32'h1000);
    tick();
    check("late_rsp_iv", instr_valid, 0);
    check("late_rsp_req", imem_req_valid, 0);
    tick();
    check("post_rst_pc", instr_pc, 32'h1000);
    check("post_rst_instr", instruction, 32'hDEAD_1000);
    tick();
    check("post_rst_next", imem_addr, 32'h1004);

    // unaligned redirect target
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2002;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_no_req", imem_req_valid, 0);
    check("mis_flag0", fetch_misaligned, 0);
    tick();
    check("mis_flag", fetch_misaligned, 1);
    check("mis_bad_pc", fetch_bad_pc, 32'h2002);
    check("mis_halt_req", imem_req_valid, 0);
    tick();
    check("mis_halt_hold", imem_req_valid, 0);
    check("mis_flag_hold", fetch_misaligned, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    tick();
    redirect_valid = 1'b0;
    check("mis_clear", fetch_misaligned, 0);
    check("mis_resume_req", imem_req_valid, 1);
    check("mis_resume_addr", imem_addr, 32'h3000);
    tick();
    tick();
    check("mis_resume_pc", instr_pc, 32'h3000);
    check("mis_resume_instr", instruction, 32'hDEAD_3000);
`else
    check("align_req", imem_req_valid, 1);
    check("align_addr", imem_addr, 32'h2000);
    tick();
    tick();
    check("align_pc", instr_pc, 32'h2000);
    check("align_instr", instruction, 32'hDEAD_2000);
`endif

    // redirect in HOLD, then PC wraps past the top of the address space
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    check("hold_redir_iv", instr_valid, 0);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_instr", instruction, 32'h2152_FFFC);
    tick();
    check("wrap_next", imem_addr, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
